format_unpacker: RTL and testbench

- Splits a packed 32-bit pixel-word stream into separate Y-plane and UV-plane sample streams, each with valid/ready.
- Sits on the read side of the video decode output path; it is the inverse of the packer that merges Y/UV bytes into DATA_W words.
- Supports NV12 8-bit and P010 10-bit layouts; all output samples are 10-bit and MSB-aligned.

---
 rtl/format_unpacker.sv | 145 ++++++++++++++
 tb/tb_format_unpacker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/format_unpacker.sv
// Splits packed 32-bit NV12 / P010 words into MSB-aligned 10-bit Y and UV sample streams.
// Optional sticky P010 padding check is compiled in with FORMAT_UNPACKER_ERRCHK_EN.
module format_unpacker #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              mode_10bit,
    output logic              y_valid,
    output logic [9:0]        y_data,
    input  logic              y_ready,
    output logic              uv_valid,
    output logic [9:0]        uv_data,
    output logic              uv_is_v,
    input  logic              uv_ready,
    output logic              fmt_err
);

    if (DATA_W != 32) begin : g_bad_width
        $error("format_unpacker: DATA_W must be 32");
    end

    typedef enum logic {
        EMPTY,
        BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] word_q;
    logic              mode_q;
    logic              y_idx_q, uv_idx_q;
    logic              y_done_q, uv_done_q;
    logic              phase_q;

    logic y_hs, uv_hs, y_last, uv_last, y_fin, uv_fin, retire, accept;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
        end else begin
            // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_d  = state_q;
        y_valid  = (state_q == BUSY) && !y_done_q;
        uv_valid = (state_q == BUSY) && !uv_done_q;
        y_hs     = y_valid && y_ready;
        uv_hs    = uv_valid && uv_ready;
        y_last   = mode_q || y_idx_q;
        uv_last  = mode_q || uv_idx_q;
        y_fin    = y_done_q || (y_hs && y_last);
        uv_fin   = uv_done_q || (uv_hs && uv_last);
        retire   = (state_q == BUSY) && y_fin && uv_fin;
        in_ready = (state_q == EMPTY) || retire;
        accept   = in_valid && in_ready;
        if (accept) begin
            state_d = BUSY;
        end else if (retire) begin
            state_d = EMPTY;
        end
    end

    // Word/progress registers; a fresh accept always wins over draining the retiring word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_q    <= '0;
            mode_q    <= 1'b0;
            y_idx_q   <= 1'b0;
            uv_idx_q  <= 1'b0;
            y_done_q  <= 1'b0;
            uv_done_q <= 1'b0;
        end else if (accept) begin
            word_q    <= in_data;
            mode_q    <= mode_10bit;
            y_idx_q   <= 1'b0;
            uv_idx_q  <= 1'b0;
            y_done_q  <= 1'b0;
            uv_done_q <= 1'b0;
        end else begin
            if (y_hs) begin
                if (y_last) y_done_q <= 1'b1;
                else        y_idx_q  <= 1'b1;
            end
            if (uv_hs) begin
                if (uv_last) uv_done_q <= 1'b1;
                else         uv_idx_q  <= 1'b1;
            end
        end
    end

    // Chroma phase persists across P010 words and is parked at U after each NV12 word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q <= 1'b0;
        end else if (uv_hs && mode_q) begin
            phase_q <= ~phase_q;
        end else if (retire && !mode_q) begin
            phase_q <= 1'b0;
        end
    end

    always_comb begin
        y_data  = '0;
        uv_data = '0;
        uv_is_v = 1'b0;
        if (y_valid) begin
            if (mode_q)       y_data = word_q[15:6];
            else if (y_idx_q) y_data = {word_q[15:8], 2'b00};
            else              y_data = {word_q[7:0], 2'b00};
        end
        if (uv_valid) begin
            if (mode_q) begin
                uv_data = word_q[31:22];
                uv_is_v = phase_q;
            end else begin
                uv_data = uv_idx_q ? {word_q[31:24], 2'b00} : {word_q[23:16], 2'b00};
                uv_is_v = uv_idx_q;
            end
        end
    end

`ifdef FORMAT_UNPACKER_ERRCHK_EN
    logic fmt_err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fmt_err_q <= 1'b0;
        end else if (accept && mode_10bit && ((|in_data[5:0]) || (|in_data[21:16]))) begin
            fmt_err_q <= 1'b1;
        end
    end

    assign fmt_err = fmt_err_q;
`else
    assign fmt_err = 1'b0;
`endif

endmodule

// File: tb/tb_format_unpacker.sv
// Self-checking bench for format_unpacker: directed cases plus randomized traffic
// scored against a queue-based model of the NV12/P010 unpacking rules.
module tb_format_unpacker;

`ifdef FORMAT_UNPACKER_ERRCHK_EN
    localparam logic ERRCHK = 1'b1;
`else
    localparam logic ERRCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        mode_10bit = 1'b0;
    logic        y_valid;
    logic [9:0]  y_data;
    logic        y_ready = 1'b0;
    logic        uv_valid;
    logic [9:0]  uv_data;
    logic        uv_is_v;
    logic        uv_ready = 1'b0;
    logic        fmt_err;

    format_unpacker #(.DATA_W(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode_10bit(mode_10bit),
        .y_valid   (y_valid),
        .y_data    (y_data),
        .y_ready   (y_ready),
        .uv_valid  (uv_valid),
        .uv_data   (uv_data),
        .uv_is_v   (uv_is_v),
        .uv_ready  (uv_ready),
        .fmt_err   (fmt_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_v;
        logic [9:0] d;
    } uv_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  y_q[$];
    uv_t         uv_q[$];
    logic        m_phase;
    logic        exp_err;
    logic        y_hold, uv_hold;
    logic [9:0]  y_hold_d;
    logic [10:0] uv_hold_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        y_q.delete();
        uv_q.delete();
        m_phase = 1'b0;
        exp_err = 1'b0;
        y_hold  = 1'b0;
        uv_hold = 1'b0;
    endtask

    // Expected samples straight from the word layouts, using plain arithmetic.
    task automatic model_accept(input logic [31:0] d, input logic m);
        int unsigned w;
        uv_t u;
        w = d;
        if (!m) begin
            for (int k = 0; k < 2; k++) y_q.push_back(10'(((w >> (8 * k)) % 256) * 4));
            for (int k = 0; k < 2; k++) begin
                u.is_v = (k == 1);
                u.d    = 10'(((w >> (16 + 8 * k)) % 256) * 4);
                uv_q.push_back(u);
            end
            m_phase = 1'b0;
        end else begin
            y_q.push_back(10'((w % 65536) / 64));
            u.is_v = m_phase;
            u.d    = 10'((w / 65536) / 64);
            uv_q.push_back(u);
            m_phase = ~m_phase;
            if ((w % 64) != 0 || ((w / 65536) % 64) != 0) exp_err = exp_err | ERRCHK;
        end
    endtask

    // One clock cycle: drive at the falling edge, settle, then score what the next rising edge commits.
    task automatic step(input logic iv, input logic [31:0] d, input logic m,
                        input logic yr, input logic ur);
        logic [31:0] e;
        @(negedge clk);
        in_valid   = iv;
        in_data    = d;
        mode_10bit = m;
        y_ready    = yr;
        uv_ready   = ur;
        #1;
        if (y_hold) begin
            check("y_hold_valid", 32'(y_valid), 32'd1);
            check("y_hold_data", 32'(y_data), 32'(y_hold_d));
        end
        if (uv_hold) begin
            check("uv_hold_valid", 32'(uv_valid), 32'd1);
            check("uv_hold_data", 32'({uv_is_v, uv_data}), 32'(uv_hold_d));
        end
        check("fmt_err", 32'(fmt_err), 32'(exp_err));
        if (y_valid && y_ready) begin
            e = (y_q.size() != 0) ? 32'(y_q.pop_front()) : 32'h800;
            check("y_sample", 32'(y_data), e);
        end
        if (uv_valid && uv_ready) begin
            e = (uv_q.size() != 0) ? 32'(uv_q.pop_front()) : 32'h800;
            check("uv_sample", 32'({uv_is_v, uv_data}), e);
        end
        y_hold    = y_valid && !y_ready;
        y_hold_d  = y_data;
        uv_hold   = uv_valid && !uv_ready;
        uv_hold_d = {uv_is_v, uv_data};
        if (in_valid && in_ready) model_accept(d, m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b0;
        in_valid = 1'b0;
        y_ready  = 1'b0;
        uv_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        m;
        int          guard;

        model_clear();
        do_reset();

        // Reset state, then NV12 0x44332211 with back-to-back accept on the V/Y1 cycle.
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_y_valid", 32'(y_valid), 32'd0);
        check("rst_uv_valid", 32'(uv_valid), 32'd0);
        check("rst_y_data", 32'(y_data), 32'd0);
        check("rst_uv_data", 32'(uv_data), 32'd0);
        check("rst_uv_is_v", 32'(uv_is_v), 32'd0);
        check("rst_fmt_err", 32'(fmt_err), 32'd0);
        step(1, 32'h44332211, 0, 1, 1);
        check("t1_y_idle", 32'(y_valid), 32'd0);
        step(1, 32'h44332211, 0, 1, 1);
        check("t1_y0", 32'(y_data), 32'h044);
        check("t1_u", 32'({uv_is_v, uv_data}), 32'h0CC);
        check("t1_busy_ready", 32'(in_ready), 32'd0);
        step(1, 32'h44332211, 0, 1, 1);
        check("t1_y1", 32'(y_data), 32'h088);
        check("t1_v", 32'({uv_is_v, uv_data}), 32'h510);
        check("t1_b2b_ready", 32'(in_ready), 32'd1);
        step(0, 32'h0, 0, 1, 1);
        check("t1_nobubble_v", 32'(y_valid), 32'd1);
        check("t1_nobubble_d", 32'(y_data), 32'h044);
        step(0, 32'h0, 0, 1, 1);
        step(0, 32'h0, 0, 1, 1);
        check("t1_idle_y", 32'(y_valid), 32'd0);
        check("t1_idle_ready", 32'(in_ready), 32'd1);

        // P010, one word per cycle, chroma alternating U then V.
        step(1, 32'hFFC08040, 1, 1, 1);
        step(1, 32'h00400000, 1, 1, 1);
        check("t2_y0", 32'(y_data), 32'h201);
        check("t2_u", 32'({uv_is_v, uv_data}), 32'h3FF);
        check("t2_ready", 32'(in_ready), 32'd1);
        step(0, 32'h0, 1, 1, 1);
        check("t2_y1", 32'({y_valid, y_data}), 32'h400);
        check("t2_v", 32'({uv_is_v, uv_data}), 32'h401);
        step(0, 32'h0, 1, 1, 1);
        check("t2_idle", 32'(y_valid), 32'd0);

        // NV12 with UV stalled for five cycles while Y drains.
        step(1, 32'h44332211, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 32'h0, 0, 1, 0);
            check("t3_stall_ready", 32'(in_ready), 32'd0);
            check("t3_stall_uv", 32'({uv_valid, uv_data}), 32'h4CC);
            if (i >= 2) check("t3_y_drained", 32'(y_valid), 32'd0);
        end
        step(0, 32'h0, 0, 1, 1);
        check("t3_u_ready", 32'(in_ready), 32'd0);
        step(0, 32'h0, 0, 1, 1);
        check("t3_v", 32'({uv_is_v, uv_data}), 32'h510);
        check("t3_retire_ready", 32'(in_ready), 32'd1);

        // mode_10bit flips mid-word: current NV12 word unaffected, next word is P010.
        step(1, 32'h88776655, 0, 1, 1);
        step(0, 32'h0, 1, 1, 1);
        check("t4_y0", 32'(y_data), 32'h154);
        step(1, 32'h80004000, 1, 1, 1);
        check("t4_y1", 32'(y_data), 32'h198);
        check("t4_v", 32'({uv_is_v, uv_data}), 32'h620);
        step(0, 32'h0, 0, 1, 1);
        check("t4_p010_y", 32'(y_data), 32'h100);
        check("t4_p010_u", 32'({uv_is_v, uv_data}), 32'h200);
        step(0, 32'h0, 0, 1, 1);
        check("t4_one_y", 32'(y_valid), 32'd0);

        // Reset after the first Y handshake discards the rest of the word.
        step(1, 32'h44332211, 0, 1, 1);
        step(0, 32'h0, 0, 1, 1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        model_clear();
        #1;
        check("t5_rst_y", 32'(y_valid), 32'd0);
        check("t5_rst_uv", 32'(uv_valid), 32'd0);
        check("t5_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 0, 1, 1);
            check("t5_no_residual", 32'({y_valid, uv_valid}), 32'd0);
        end

        // P010 padding error is sticky when the check is built in.
        step(1, 32'h00010000, 1, 1, 1);
        check("t6_err_before", 32'(fmt_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 1, 1, 1);
            check("t6_err_sticky", 32'(fmt_err), 32'(ERRCHK));
        end

        // Randomized traffic with random backpressure and mode.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            d = $urandom;
            m = 1'($urandom_range(0, 1));
            if (m && $urandom_range(0, 3) != 0) d = d & 32'hFFC0FFC0;
            step(($urandom_range(0, 9) < 7), d, m,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
        end
        guard = 0;
        while ((y_q.size() != 0 || uv_q.size() != 0) && guard < 50) begin
            step(0, 32'h0, 0, 1, 1);
            guard++;
        end
        check("drain_y_empty", 32'(y_q.size()), 32'd0);
        check("drain_uv_empty", 32'(uv_q.size()), 32'd0);
        step(0, 32'h0, 0, 1, 1);
        check("drain_idle", 32'({y_valid, uv_valid, in_ready}), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
